// File: rtl/sha_core_arbiter.sv
// sha_core_arbiter
// Shares one SHA-512 core between two requester message streams.
// Whole messages are granted round-robin onto the core input. Each digest is
// routed back to its issuer using an in-order ticket FIFO, one ticket per
// granted message.
//
// Ports
//   aclk, areset        clock, asynchronous active-high reset
//   s0_axis_*, s1_axis_* requester message streams (in)
//   m_core_*            message stream to the hash core (out)
//   s_core_*            digest stream from the hash core (in)
//   r0_axis_*, r1_axis_* digest streams back to the requesters (out)
//   outstanding         tickets currently held (messages inside the core)
//   err_orphan          digest beat seen while no ticket is held (dropped)
//
// state | meaning
// IDLE  | no grant; arbitrate when a requester is valid and a ticket slot is free
// GNT0  | requester 0 connected to the core until its tlast handshakes
// GNT1  | requester 1 connected to the core until its tlast handshakes
module sha_core_arbiter #(
  parameter int DATA_WIDTH      = 512,
  parameter int ID_WIDTH        = 6,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          s0_axis_tvalid,
  output logic                          s0_axis_tready,
  input  logic [DATA_WIDTH-1:0]         s0_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]       s0_axis_tkeep,
  input  logic [ID_WIDTH-1:0]           s0_axis_tid,
  input  logic                          s0_axis_tlast,
  input  logic                          s1_axis_tvalid,
  output logic                          s1_axis_tready,
  input  logic [DATA_WIDTH-1:0]         s1_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]       s1_axis_tkeep,
  input  logic [ID_WIDTH-1:0]           s1_axis_tid,
  input  logic                          s1_axis_tlast,
  output logic                          m_core_tvalid,
  input  logic                          m_core_tready,
  output logic [DATA_WIDTH-1:0]         m_core_tdata,
  output logic [DATA_WIDTH/8-1:0]       m_core_tkeep,
  output logic [ID_WIDTH-1:0]           m_core_tid,
  output logic                          m_core_tlast,
  input  logic                          s_core_tvalid,
  output logic                          s_core_tready,
  input  logic [DATA_WIDTH-1:0]         s_core_tdata,
  input  logic [DATA_WIDTH/8-1:0]       s_core_tkeep,
  input  logic [ID_WIDTH-1:0]           s_core_tid,
  input  logic                          s_core_tlast,
  output logic                          r0_axis_tvalid,
  input  logic                          r0_axis_tready,
  output logic [DATA_WIDTH-1:0]         r0_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]       r0_axis_tkeep,
  output logic [ID_WIDTH-1:0]           r0_axis_tid,
  output logic                          r0_axis_tlast,
  output logic                          r1_axis_tvalid,
  input  logic                          r1_axis_tready,
  output logic [DATA_WIDTH-1:0]         r1_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]       r1_axis_tkeep,
  output logic [ID_WIDTH-1:0]           r1_axis_tid,
  output logic                          r1_axis_tlast,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                          err_orphan
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t               state, state_nxt;
  logic                 rr, rr_nxt;
  logic                 push, pop, grant_sel;
  logic [MAX_OUTSTANDING-1:0] ticket;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 head, empty;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      rr    <= 1'b0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    rr_nxt         = rr;
    push           = 1'b0;
    grant_sel      = 1'b0;
    m_core_tvalid  = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state)
      IDLE: begin
        // Gating on a free slot guarantees the ticket FIFO never overflows.
        if ((s0_axis_tvalid || s1_axis_tvalid) && (count < MAX_CNT)) begin
          push      = 1'b1;
          grant_sel = (s0_axis_tvalid && s1_axis_tvalid) ? rr : s1_axis_tvalid;
          state_nxt = grant_sel ? GNT1 : GNT0;
          rr_nxt    = ~grant_sel;
        end
      end
      GNT0: begin
        m_core_tvalid  = s0_axis_tvalid;
        s0_axis_tready = m_core_tready;
        if (s0_axis_tvalid && m_core_tready && s0_axis_tlast) state_nxt = IDLE;
      end
      GNT1: begin
        m_core_tvalid  = s1_axis_tvalid;
        s1_axis_tready = m_core_tready;
        if (s1_axis_tvalid && m_core_tready && s1_axis_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m_core_tdata = (state == GNT1) ? s1_axis_tdata : s0_axis_tdata;
  assign m_core_tkeep = (state == GNT1) ? s1_axis_tkeep : s0_axis_tkeep;
  assign m_core_tid   = (state == GNT1) ? s1_axis_tid   : s0_axis_tid;
  assign m_core_tlast = (state == GNT1) ? s1_axis_tlast : s0_axis_tlast;

  // Ticket FIFO: one bit per message in flight, naming the requester.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ticket <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ticket[wr_ptr] <= grant_sel;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = ticket[rd_ptr];
  assign empty = (count == '0);

  // s_core_tready and err_orphan are forced low in reset because the
  // orphan path would otherwise accept beats while the FIFO is cleared.
  always_comb begin
    r0_axis_tvalid = 1'b0;
    r1_axis_tvalid = 1'b0;
    s_core_tready  = 1'b0;
    err_orphan     = 1'b0;
    if (!areset) begin
      if (empty) begin
        s_core_tready = 1'b1;
        err_orphan    = s_core_tvalid;
      end else if (head) begin
        r1_axis_tvalid = s_core_tvalid;
        s_core_tready  = r1_axis_tready;
      end else begin
        r0_axis_tvalid = s_core_tvalid;
        s_core_tready  = r0_axis_tready;
      end
    end
  end

  assign pop = !empty && s_core_tvalid && s_core_tready && s_core_tlast;

  assign r0_axis_tdata = s_core_tdata;
  assign r0_axis_tkeep = s_core_tkeep;
  assign r0_axis_tid   = s_core_tid;
  assign r0_axis_tlast = s_core_tlast;
  assign r1_axis_tdata = s_core_tdata;
  assign r1_axis_tkeep = s_core_tkeep;
  assign r1_axis_tid   = s_core_tid;
  assign r1_axis_tlast = s_core_tlast;

  assign outstanding = count;

endmodule

// File: tb/tb_sha_core_arbiter.sv
module tb_sha_core_arbiter;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int IW = 6;

  logic aclk = 1'b0;
  logic areset;
  logic s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
  logic [DW-1:0] s0_axis_tdata;
  logic [KW-1:0] s0_axis_tkeep;
  logic [IW-1:0] s0_axis_tid;
  logic s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
  logic [DW-1:0] s1_axis_tdata;
  logic [KW-1:0] s1_axis_tkeep;
  logic [IW-1:0] s1_axis_tid;
  logic m_core_tvalid, m_core_tready, m_core_tlast;
  logic [DW-1:0] m_core_tdata;
  logic [KW-1:0] m_core_tkeep;
  logic [IW-1:0] m_core_tid;
  logic s_core_tvalid, s_core_tready, s_core_tlast;
  logic [DW-1:0] s_core_tdata;
  logic [KW-1:0] s_core_tkeep;
  logic [IW-1:0] s_core_tid;
  logic r0_axis_tvalid, r0_axis_tready, r0_axis_tlast;
  logic [DW-1:0] r0_axis_tdata;
  logic [KW-1:0] r0_axis_tkeep;
  logic [IW-1:0] r0_axis_tid;
  logic r1_axis_tvalid, r1_axis_tready, r1_axis_tlast;
  logic [DW-1:0] r1_axis_tdata;
  logic [KW-1:0] r1_axis_tkeep;
  logic [IW-1:0] r1_axis_tid;
  logic [2:0] outstanding;
  logic err_orphan;

  sha_core_arbiter #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(4)) dut (
    .aclk(aclk), .areset(areset),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready), .s0_axis_tdata(s0_axis_tdata),
    .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tid(s0_axis_tid), .s0_axis_tlast(s0_axis_tlast),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready), .s1_axis_tdata(s1_axis_tdata),
    .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tid(s1_axis_tid), .s1_axis_tlast(s1_axis_tlast),
    .m_core_tvalid(m_core_tvalid), .m_core_tready(m_core_tready), .m_core_tdata(m_core_tdata),
    .m_core_tkeep(m_core_tkeep), .m_core_tid(m_core_tid), .m_core_tlast(m_core_tlast),
    .s_core_tvalid(s_core_tvalid), .s_core_tready(s_core_tready), .s_core_tdata(s_core_tdata),
    .s_core_tkeep(s_core_tkeep), .s_core_tid(s_core_tid), .s_core_tlast(s_core_tlast),
    .r0_axis_tvalid(r0_axis_tvalid), .r0_axis_tready(r0_axis_tready), .r0_axis_tdata(r0_axis_tdata),
    .r0_axis_tkeep(r0_axis_tkeep), .r0_axis_tid(r0_axis_tid), .r0_axis_tlast(r0_axis_tlast),
    .r1_axis_tvalid(r1_axis_tvalid), .r1_axis_tready(r1_axis_tready), .r1_axis_tdata(r1_axis_tdata),
    .r1_axis_tkeep(r1_axis_tkeep), .r1_axis_tid(r1_axis_tid), .r1_axis_tlast(r1_axis_tlast),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  typedef struct {
    int            route;
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          last;
  } res_t;

  // l0/l1: tlast driven; g: requester expected on the core (-1 none);
  // ticket: requester granted this cycle (-1 none); outs: outstanding seen.
  typedef struct {
    logic l0;
    logic l1;
    int   g;
    int   ticket;
    int   outs;
  } vec_t;

  beat_t m_q[$];
  res_t  r_q[$];
  int    tq[$];
  vec_t  vt[14];
  int    tests = 0;
  int    fails = 0;
  beat_t me;
  res_t  re;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: record the beat expected on the core, check readies mid-cycle.
  task automatic tick(input int g);
    beat_t b;
    if (g == 0) begin
      b.data = s0_axis_tdata; b.keep = s0_axis_tkeep; b.id = s0_axis_tid; b.last = s0_axis_tlast;
      m_q.push_back(b);
    end else if (g == 1) begin
      b.data = s1_axis_tdata; b.keep = s1_axis_tkeep; b.id = s1_axis_tid; b.last = s1_axis_tlast;
      m_q.push_back(b);
    end
    @(negedge aclk);
    chk("s0_tready", s0_axis_tready, g == 0);
    chk("s1_tready", s1_axis_tready, g == 1);
    chk("m_tvalid", m_core_tvalid, g >= 0);
    @(posedge aclk); #1;
  endtask

  // Drive a digest beat; the expected route comes from the bench ticket model.
  task automatic digest(input logic [7:0] d, input logic [IW-1:0] id, input logic last);
    res_t r;
    s_core_tvalid = 1'b1;
    s_core_tdata  = DW'(d);
    s_core_tkeep  = '1;
    s_core_tid    = id;
    s_core_tlast  = last;
    if (tq.size() > 0) begin
      r.route = tq[0]; r.data = DW'(d); r.id = id; r.last = last;
      r_q.push_back(r);
      if (last) void'(tq.pop_front());
    end
  endtask

  always @(negedge aclk) begin
    if (!areset && m_core_tvalid && m_core_tready) begin
      if (m_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL m_unexpected: got beat %0h expected none at %0t", m_core_tdata, $time);
      end else begin
        me = m_q.pop_front();
        chk("m_tdata", m_core_tdata, me.data);
        chk("m_tkeep", m_core_tkeep, me.keep);
        chk("m_tid", m_core_tid, me.id);
        chk("m_tlast", m_core_tlast, me.last);
      end
    end
  end

  always @(negedge aclk) begin
    if (!areset && s_core_tvalid && s_core_tready && (r0_axis_tvalid || r1_axis_tvalid)) begin
      chk("r_onehot", r0_axis_tvalid & r1_axis_tvalid, 1'b0);
      if (r_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL r_unexpected: got digest %0h expected none at %0t", s_core_tdata, $time);
      end else begin
        re = r_q.pop_front();
        chk("r_route", r1_axis_tvalid, re.route == 1);
        chk("r_tdata", r1_axis_tvalid ? r1_axis_tdata : r0_axis_tdata, re.data);
        chk("r_tid", r1_axis_tvalid ? r1_axis_tid : r0_axis_tid, re.id);
        chk("r_tlast", r1_axis_tvalid ? r1_axis_tlast : r0_axis_tlast, re.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b0, 1'b0, -1,  0, 0};
    vt[1]  = '{1'b0, 1'b0,  0, -1, 1};
    vt[2]  = '{1'b1, 1'b0,  0, -1, 1};
    vt[3]  = '{1'b0, 1'b0, -1,  1, 1};
    vt[4]  = '{1'b0, 1'b0,  1, -1, 2};
    vt[5]  = '{1'b0, 1'b1,  1, -1, 2};
    vt[6]  = '{1'b0, 1'b0, -1,  0, 2};
    vt[7]  = '{1'b0, 1'b0,  0, -1, 3};
    vt[8]  = '{1'b1, 1'b0,  0, -1, 3};
    vt[9]  = '{1'b0, 1'b0, -1,  1, 3};
    vt[10] = '{1'b0, 1'b0,  1, -1, 4};
    vt[11] = '{1'b0, 1'b1,  1, -1, 4};
    vt[12] = '{1'b0, 1'b0, -1, -1, 4};
    vt[13] = '{1'b0, 1'b0, -1, -1, 4};

    areset = 1'b1;
    s0_axis_tvalid = 1'b1; s0_axis_tdata = '0; s0_axis_tkeep = '1; s0_axis_tid = 6'd1; s0_axis_tlast = 1'b0;
    s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tkeep = {8{8'h0F}}; s1_axis_tid = 6'd2; s1_axis_tlast = 1'b0;
    m_core_tready = 1'b1;
    s_core_tvalid = 1'b1; s_core_tdata = '0; s_core_tkeep = '1; s_core_tid = '0; s_core_tlast = 1'b1;
    r0_axis_tready = 1'b1; r1_axis_tready = 1'b1;

    // Reset state, with inputs active that would otherwise provoke handshakes.
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_s0_tready", s0_axis_tready, 1'b0);
    chk("rst_m_tvalid", m_core_tvalid, 1'b0);
    chk("rst_s_core_tready", s_core_tready, 1'b0);
    chk("rst_r0_tvalid", r0_axis_tvalid, 1'b0);
    chk("rst_r1_tvalid", r1_axis_tvalid, 1'b0);
    chk("rst_outstanding", outstanding, 3'd0);
    chk("rst_err_orphan", err_orphan, 1'b0);
    @(posedge aclk); #1;
    areset = 1'b0; s0_axis_tvalid = 1'b0; s_core_tvalid = 1'b0;
    @(posedge aclk); #1;

    // Both requesters valid, 2-beat packets, results held off until 4 in flight.
    for (int i = 0; i < 14; i++) begin
      s0_axis_tvalid = 1'b1; s0_axis_tlast = vt[i].l0; s0_axis_tdata = DW'(8'h10 + i);
      s1_axis_tvalid = 1'b1; s1_axis_tlast = vt[i].l1; s1_axis_tdata = DW'(8'h20 + i);
      if (vt[i].ticket >= 0) tq.push_back(vt[i].ticket);
      chk("tbl_outstanding", outstanding, vt[i].outs);
      tick(vt[i].g);
    end

    // First digest pops while full; grant follows in the next cycle,
    // together with a second digest pop (push and pop in the same cycle).
    digest(8'hD1, 6'd9, 1'b1);
    tick(-1);
    chk("pop_outstanding", outstanding, 3'd3);
    digest(8'hD2, 6'd10, 1'b1);
    tq.push_back(0);
    tick(-1);
    chk("pushpop_outstanding", outstanding, 3'd3);
    s_core_tvalid = 1'b0;
    s0_axis_tdata = DW'(8'h30); s0_axis_tlast = 1'b1;
    tick(0);
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    tick(-1);

    // Drain the remaining tickets, including a backpressured digest.
    digest(8'hE0, 6'd11, 1'b0); tick(-1);
    digest(8'hE1, 6'd11, 1'b1); tick(-1);
    r1_axis_tready = 1'b0;
    s_core_tvalid = 1'b1; s_core_tdata = DW'(8'hE2); s_core_tid = 6'd12; s_core_tlast = 1'b1;
    @(negedge aclk);
    chk("bp_s_core_tready", s_core_tready, 1'b0);
    chk("bp_r1_tvalid", r1_axis_tvalid, 1'b1);
    chk("bp_r0_tvalid", r0_axis_tvalid, 1'b0);
    @(posedge aclk); #1;
    r1_axis_tready = 1'b1;
    digest(8'hE2, 6'd12, 1'b1); tick(-1);
    digest(8'hE3, 6'd13, 1'b1); tick(-1);
    s_core_tvalid = 1'b0;
    chk("drain_outstanding", outstanding, 3'd0);

    // Lone s0 3-beat packet, tid 5.
    s0_axis_tvalid = 1'b1; s0_axis_tid = 6'd5; s0_axis_tdata = DW'(8'h51); s0_axis_tlast = 1'b0;
    tq.push_back(0);
    tick(-1);
    chk("t1_outstanding1", outstanding, 3'd1);
    tick(0);
    s0_axis_tdata = DW'(8'h52); tick(0);
    s0_axis_tdata = DW'(8'h53); s0_axis_tlast = 1'b1; tick(0);
    s0_axis_tvalid = 1'b0;
    digest(8'hAA, 6'd5, 1'b1); tick(-1);
    s_core_tvalid = 1'b0;
    chk("t1_outstanding0", outstanding, 3'd0);

    // Orphan digest with an empty ticket FIFO.
    s_core_tvalid = 1'b1; s_core_tdata = DW'(8'hBB); s_core_tid = 6'd7; s_core_tlast = 1'b1;
    @(negedge aclk);
    chk("orph_s_core_tready", s_core_tready, 1'b1);
    chk("orph_err", err_orphan, 1'b1);
    chk("orph_r0_tvalid", r0_axis_tvalid, 1'b0);
    chk("orph_r1_tvalid", r1_axis_tvalid, 1'b0);
    @(posedge aclk); #1;
    s_core_tvalid = 1'b0;
    @(negedge aclk);
    chk("orph_err_pulse", err_orphan, 1'b0);
    @(posedge aclk); #1;

    // Reset in the middle of a GNT1 packet.
    s0_axis_tid = 6'd1;
    s1_axis_tvalid = 1'b1; s1_axis_tdata = DW'(8'h61); s1_axis_tlast = 1'b0;
    tq.push_back(1);
    tick(-1);
    tick(1);
    s1_axis_tdata = DW'(8'h62);
    s0_axis_tvalid = 1'b1; s0_axis_tdata = DW'(8'h71); s0_axis_tlast = 1'b1;
    s_core_tvalid = 1'b1; s_core_tdata = DW'(8'hEE); s_core_tlast = 1'b1;
    #1 areset = 1'b1;
    #1;
    chk("ar_s1_tready", s1_axis_tready, 1'b0);
    chk("ar_s0_tready", s0_axis_tready, 1'b0);
    chk("ar_m_tvalid", m_core_tvalid, 1'b0);
    chk("ar_s_core_tready", s_core_tready, 1'b0);
    chk("ar_r1_tvalid", r1_axis_tvalid, 1'b0);
    chk("ar_outstanding", outstanding, 3'd0);
    chk("ar_err_orphan", err_orphan, 1'b0);
    tq.delete();
    @(posedge aclk); #1;
    areset = 1'b0; s_core_tvalid = 1'b0;
    tq.push_back(0);
    tick(-1);
    tick(0);
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    tick(-1);
    chk("post_rst_outstanding", outstanding, 3'd1);
    digest(8'hCC, 6'd1, 1'b1); tick(-1);
    s_core_tvalid = 1'b0;
    chk("end_outstanding", outstanding, 3'd0);
    chk("end_m_q_empty", m_q.size(), 0);
    chk("end_r_q_empty", r_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
